keypad_key_decoder: RTL
=======================

// Module: keypad_key_decoder
// PURPOSE
//   Converts the PS/2 scan-code byte stream from the keyboard receiver into per-key press pulses and held levels.
//   Feeds the screen controllers, such as the welcome screen's flipper-type selection (keypad 4 / keypad 6).
//   Decodes E0 (extended) and F0 (break) prefixes, suppresses typematic repeats and recovers from broken sequences.
// PARAMETERS
//   KEY4_CODE       8'h6B    scan code, keypad 4 (non-extended)
//   KEY5_CODE       8'h73    scan code, keypad 5 (non-extended)
//   KEY6_CODE       8'h74    scan code, keypad 6 (non-extended)
//   ENTER_CODE      8'h5A    scan code, keypad Enter (extended only)
//   PREFIX_TIMEOUT  250000   max clk cycles between a prefix byte and its follower (5 ms @ 50 MHz); >= 2
// PORTS
//   clk               in   1  system clock, all logic on rising edge
//   reset             in   1  asynchronous, active-high reset
//   kbdData           in   8  scan-code byte from the PS/2 receiver
//   kbdDataValid      in   1  1-cycle strobe: kbdData valid this cycle
//   key4IsPressed     out  1  1-cycle pulse on a new keypad-4 press
//   key5IsPressed     out  1  1-cycle pulse on a new keypad-5 press
//   key6IsPressed     out  1  1-cycle pulse on a new keypad-6 press
//   keyEnterIsPressed out  1  1-cycle pulse on a new keypad-Enter press
//   key4IsHeld        out  1  level: keypad 4 currently down
//   key5IsHeld        out  1  level: keypad 5 currently down
//   key6IsHeld        out  1  level: keypad 6 currently down
//   keyEnterIsHeld    out  1  level: keypad Enter currently down
//   protocolError     out  1  1-cycle pulse on an illegal sequence or a prefix timeout
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-sequence discards any pending prefix.
//   All outputs are registered. kbdData is sampled only when kbdDataValid=1.
//   FSM states and transitions on a valid byte:
//   - IDLE:      E0 -> EXT; F0 -> BREAK; other -> MAKE(code, ext=0), stay IDLE.
//   - EXT:       F0 -> EXT_BREAK; E0 -> protocolError, stay EXT; other -> MAKE(code, ext=1), -> IDLE.
//   - BREAK:     E0 or F0 -> protocolError, -> IDLE; other -> BRK(code, ext=0), -> IDLE.
//   - EXT_BREAK: E0 or F0 -> protocolError, -> IDLE; other -> BRK(code, ext=1), -> IDLE.
//   Key matching:
//   - KEY4/5/6 match only with ext=0.
//   - ENTER matches only with ext=1; a plain 5A (main Enter) is ignored.
//   - Unmatched codes are silently ignored (no error).
//   MAKE on a matched key:
//   - Held=0: Held<=1 and the IsPressed pulse is high exactly 1 cycle, on the cycle after the strobe (latency 1).
//   - Held=1 (typematic repeat): no pulse, Held stays 1.
//   BRK on a matched key: Held<=0 on the next edge; no pulse. BRK of a key that is not held: no effect.
//   Keys are independent: any combination may be held at once, and a pulse on one key never alters another.
//   Timeout counter:
//   - Cleared on entry to any non-IDLE state, and on every valid byte.
//   - Increments each cycle while not in IDLE.
//   - On reaching PREFIX_TIMEOUT-1: -> IDLE and protocolError pulses for 1 cycle; Held levels unchanged.
//   - Timeout and kbdDataValid in the same cycle: the byte wins (processed normally, no error).
//   - Counter width $clog2(PREFIX_TIMEOUT); no wrap, since it is cleared before saturating.
//   protocolError fires at most once per offending byte or timeout, 1 cycle after the cause.
// TESTING (bench uses PREFIX_TIMEOUT=16; one strobe per byte, >=3 idle cycles between bytes)
//   1. Bytes 6B, 6B, 6B, F0 6B:
//      -> key4IsPressed high exactly 1 cycle after the first strobe, only once.
//      -> key4IsHeld 1 from then until the cycle after the final 6B, then 0.
//   2. Bytes E0 5A, E0 F0 5A, 5A:
//      -> keyEnterIsPressed pulses once and keyEnterIsHeld goes 1 then 0.
//      -> the plain 5A produces no output change.
//   3. Bytes F0 F0, 74:
//      -> protocolError pulse 1 cycle after the second F0.
//      -> 74 decodes as a make: key6IsPressed pulse, key6IsHeld=1.
//   4. E0, then 16 idle cycles, then 5A:
//      -> protocolError pulse at the timeout and FSM returns to IDLE.
//      -> 5A is treated as non-extended, so there is no Enter pulse.
//   5. Bytes 6B, 74, F0 6B:
//      -> both keys held, then key4IsHeld=0 while key6IsHeld=1.
//      -> no spurious key6 pulse.
//   6. 6B, then F0, then reset pulse, then 6B:
//      -> all outputs 0 during reset.
//      -> the post-reset 6B gives a key4IsPressed pulse (make, not break).

Source files
------------

// File: rtl/keypad_key_decoder.sv
// keypad_key_decoder
// Turns the PS/2 scan-code byte stream into per-key press pulses and held
// levels for keypad 4/5/6 and keypad Enter. Handles the E0 (extended) and
// F0 (break) prefixes, drops typematic repeats, and returns to IDLE with a
// protocolError pulse on an illegal prefix sequence or a prefix timeout.
//
// Handshake: kbdDataValid is a 1-cycle strobe with no back-pressure; kbdData
// is sampled only in cycles where kbdDataValid=1, and every such byte is
// consumed. All outputs are registered and appear one cycle after the cause.
//
// Key vectors internally are ordered {enter, key6, key5, key4}.
module keypad_key_decoder #(
  parameter logic [7:0] KEY4_CODE      = 8'h6B,
  parameter logic [7:0] KEY5_CODE      = 8'h73,
  parameter logic [7:0] KEY6_CODE      = 8'h74,
  parameter logic [7:0] ENTER_CODE     = 8'h5A,
  parameter int         PREFIX_TIMEOUT = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kbdData,
  input  logic       kbdDataValid,
  output logic       key4IsPressed,
  output logic       key5IsPressed,
  output logic       key6IsPressed,
  output logic       keyEnterIsPressed,
  output logic       key4IsHeld,
  output logic       key5IsHeld,
  output logic       key6IsHeld,
  output logic       keyEnterIsHeld,
  output logic       protocolError,
  output logic [1:0] debugState
);

  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam int         CNT_W      = $clog2(PREFIX_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXT       = 2'd1,
    BREAK     = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             errNext;
  logic             decodeMake;
  logic             decodeBrk;
  logic             decodeExt;
  logic             timeoutHit;
  logic [3:0]       matchVec;
  logic [3:0]       held, heldNext;
  logic [3:0]       pressed, pressedNext;

  // Prefix timer expires only while a prefix is pending.
  assign timeoutHit = (state != IDLE) && (cnt == CNT_LAST);

  // Which tracked key (if any) the current byte names, given extension.
  always_comb begin
    matchVec    = 4'b0000;
    matchVec[0] = !decodeExt && (kbdData == KEY4_CODE);
    matchVec[1] = !decodeExt && (kbdData == KEY5_CODE);
    matchVec[2] = !decodeExt && (kbdData == KEY6_CODE);
    matchVec[3] =  decodeExt && (kbdData == ENTER_CODE);
  end

  // Next-state, timer and decode strobes; a valid byte beats a timeout.
  always_comb begin
    nextState  = state;
    cntNext    = cnt;
    errNext    = 1'b0;
    decodeMake = 1'b0;
    decodeBrk  = 1'b0;
    decodeExt  = 1'b0;
    if (kbdDataValid) begin
      cntNext = '0;
      case (state)
        IDLE: begin
          if (kbdData == EXT_PREFIX) begin
            nextState = EXT;
          end else if (kbdData == BRK_PREFIX) begin
            nextState = BREAK;
          end else begin
            decodeMake = 1'b1;
          end
        end
        EXT: begin
          if (kbdData == BRK_PREFIX) begin
            nextState = EXT_BREAK;
          end else if (kbdData == EXT_PREFIX) begin
            errNext = 1'b1;
          end else begin
            decodeMake = 1'b1;
            decodeExt  = 1'b1;
            nextState  = IDLE;
          end
        end
        BREAK: begin
          nextState = IDLE;
          if ((kbdData == EXT_PREFIX) || (kbdData == BRK_PREFIX)) begin
            errNext = 1'b1;
          end else begin
            decodeBrk = 1'b1;
          end
        end
        EXT_BREAK: begin
          nextState = IDLE;
          if ((kbdData == EXT_PREFIX) || (kbdData == BRK_PREFIX)) begin
            errNext = 1'b1;
          end else begin
            decodeBrk = 1'b1;
            decodeExt = 1'b1;
          end
        end
        default: nextState = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (timeoutHit) begin
        nextState = IDLE;
        errNext   = 1'b1;
        cntNext   = '0;
      end else begin
        cntNext = cnt + 1'b1;
      end
    end
  end

  // Held levels and new-press pulses; repeats of a held key do not pulse.
  always_comb begin
    pressedNext = 4'b0000;
    heldNext    = held;
    if (decodeMake) begin
      pressedNext = matchVec & ~held;
      heldNext    = held | matchVec;
    end else if (decodeBrk) begin
      heldNext = held & ~matchVec;
    end
  end

  // State, timer and all output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      held          <= 4'b0000;
      pressed       <= 4'b0000;
      protocolError <= 1'b0;
    end else begin
      state         <= nextState;
      cnt           <= cntNext;
      held          <= heldNext;
      pressed       <= pressedNext;
      protocolError <= errNext;
    end
  end

  assign key4IsPressed     = pressed[0];
  assign key5IsPressed     = pressed[1];
  assign key6IsPressed     = pressed[2];
  assign keyEnterIsPressed = pressed[3];
  assign key4IsHeld        = held[0];
  assign key5IsHeld        = held[1];
  assign key6IsHeld        = held[2];
  assign keyEnterIsHeld    = held[3];
  assign debugState        = state;

endmodule
